// File: rtl/spi_pkg.sv
// Shared constants and state encodings for the SPI flash read sequencer.
package spi_pkg;

    localparam logic [2:0] SPI_REG_DATA    = 3'd0;
    localparam logic [2:0] SPI_REG_NEXT    = 3'd1;
    localparam logic [2:0] SPI_REG_READY   = 3'd2;
    localparam logic [2:0] SPI_REG_INT     = 3'd3;
    localparam logic [2:0] SPI_REG_MODE    = 3'd4;
    localparam logic [2:0] SPI_REG_CLK     = 3'd5;
    localparam logic [2:0] SPI_REG_TIMEOUT = 3'd7;

    localparam logic [7:0] FLASH_READ_CMD  = 8'h03;
    localparam logic [7:0] FLASH_DUMMY     = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_A2,
        ST_A1,
        ST_A0,
        ST_RD,
        ST_CAP,
        ST_OUT,
        ST_END,
        ST_DONE
    } fsm_state_e;

    typedef enum logic [1:0] {
        STEP_IDLE,
        STEP_STROBE,
        STEP_WAIT1,
        STEP_POLL
    } step_state_e;

endpackage

// File: rtl/spi_byte_step.sv
// One spi register "byte step": strobe data reg (write byte or end-read), skip a cycle, poll ready.
module spi_byte_step
    import spi_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        end_i,
    input  logic [7:0]  byte_i,
    input  logic        ready_i,
    output logic [2:0]  spi_addr_o,
    output logic [7:0]  spi_data_o,
    output logic        spi_read_o,
    output logic        spi_write_o,
    output logic        done_o,
    output step_state_e state_o
);

    step_state_e state_q;
    logic [2:0]  addr_q;
    logic [7:0]  data_q;
    logic        rd_q;
    logic        wr_q;
    logic        done_q;

    // WAIT1 exists because ready only falls one cycle after the strobe.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= STEP_IDLE;
            addr_q  <= SPI_REG_READY;
            data_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                STEP_IDLE: begin
                    if (start_i) begin
                        state_q <= STEP_STROBE;
                        addr_q  <= SPI_REG_DATA;
                        data_q  <= byte_i;
                        wr_q    <= !end_i;
                        rd_q    <= end_i;
                    end
                end
                STEP_STROBE: begin
                    state_q <= STEP_WAIT1;
                    addr_q  <= SPI_REG_READY;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                end
                STEP_WAIT1: state_q <= STEP_POLL;
                STEP_POLL: begin
                    if (ready_i) begin
                        state_q <= STEP_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= STEP_IDLE;
            endcase
        end
    end

    assign spi_addr_o  = addr_q;
    assign spi_data_o  = data_q;
    assign spi_read_o  = rd_q;
    assign spi_write_o = wr_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Serial-flash READ sequencer sharing the spi register port with the CPU; streams bytes out.
module spi_flash_reader
    import spi_pkg::*;
#(
    parameter int         LEN_W    = 8,
    parameter logic [7:0] READ_CMD = FLASH_READ_CMD
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [23:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [1:0]       req_sel_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_last_o,
    output logic             done_o,
    input  logic [2:0]       cpu_reg_addr_i,
    input  logic [7:0]       cpu_reg_data_in_i,
    input  logic [1:0]       cpu_reg_sel_i,
    input  logic             cpu_reg_read_i,
    input  logic             cpu_reg_write_i,
    output logic [7:0]       cpu_data_out_o,
    output logic             cpu_busy_o,
    output logic [2:0]       spi_reg_addr_o,
    output logic [7:0]       spi_reg_data_in_o,
    output logic [1:0]       spi_reg_sel_o,
    output logic             spi_reg_read_o,
    output logic             spi_reg_write_o,
    input  logic [7:0]       spi_data_out_i,
    output fsm_state_e       state_o,
    output step_state_e      step_state_o
);

    fsm_state_e       state_q;
    logic             cpu_txn_q;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] remaining_q;
    logic [1:0]       sel_q;
    logic             rd_valid_q;
    logic             rd_last_q;
    logic [7:0]       rd_data_q;
    logic             done_q;
    logic             busy_q;
    logic             step_start_q;
    logic             step_end_q;
    logic [7:0]       step_byte_q;

    logic [2:0] step_addr;
    logic [7:0] step_data;
    logic       step_read;
    logic       step_write;
    logic       step_done;
    logic       req_accept;

    spi_byte_step u_step (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (step_start_q),
        .end_i       (step_end_q),
        .byte_i      (step_byte_q),
        .ready_i     (spi_data_out_i[0]),
        .spi_addr_o  (step_addr),
        .spi_data_o  (step_data),
        .spi_read_o  (step_read),
        .spi_write_o (step_write),
        .done_o      (step_done),
        .state_o     (step_state_o)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready; req_valid and
    // rd_valid hold their payload stable until then. The CPU wins any same-cycle conflict.
    assign req_accept = reset_i && (state_q == ST_IDLE) && !cpu_txn_q && req_valid_i
                        && !cpu_reg_read_i && !cpu_reg_write_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            cpu_txn_q    <= 1'b0;
            addr_q       <= '0;
            remaining_q  <= '0;
            sel_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            step_start_q <= 1'b0;
            step_end_q   <= 1'b0;
            step_byte_q  <= '0;
        end else begin
            step_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_reg_write_i && cpu_reg_addr_i == SPI_REG_DATA && !cpu_txn_q)
                        cpu_txn_q <= 1'b1;
                    if (cpu_reg_read_i && cpu_reg_addr_i == SPI_REG_DATA)
                        cpu_txn_q <= 1'b0;
                    if (req_accept) begin
                        addr_q       <= req_addr_i;
                        remaining_q  <= req_len_i;
                        sel_q        <= req_sel_i;
                        busy_q       <= 1'b1;
                        state_q      <= ST_CMD;
                        step_start_q <= 1'b1;
                        step_end_q   <= 1'b0;
                        step_byte_q  <= READ_CMD;
                    end
                end
                ST_CMD: if (step_done) begin
                    state_q      <= ST_A2;
                    step_start_q <= 1'b1;
                    step_byte_q  <= addr_q[23:16];
                end
                ST_A2: if (step_done) begin
                    state_q      <= ST_A1;
                    step_start_q <= 1'b1;
                    step_byte_q  <= addr_q[15:8];
                end
                ST_A1: if (step_done) begin
                    state_q      <= ST_A0;
                    step_start_q <= 1'b1;
                    step_byte_q  <= addr_q[7:0];
                end
                ST_A0: if (step_done) begin
                    state_q      <= ST_RD;
                    step_start_q <= 1'b1;
                    step_byte_q  <= FLASH_DUMMY;
                end
                ST_RD: if (step_done) state_q <= ST_CAP;
                ST_CAP: begin
                    rd_data_q  <= spi_data_out_i;
                    rd_valid_q <= 1'b1;
                    rd_last_q  <= (remaining_q == '0);
                    state_q    <= ST_OUT;
                end
                ST_OUT: if (rd_ready_i) begin
                    rd_valid_q   <= 1'b0;
                    rd_last_q    <= 1'b0;
                    step_start_q <= 1'b1;
                    if (remaining_q == '0) begin
                        state_q    <= ST_END;
                        step_end_q <= 1'b1;
                    end else begin
                        remaining_q <= remaining_q - 1'b1;
                        state_q     <= ST_RD;
                        step_byte_q <= FLASH_DUMMY;
                    end
                end
                ST_END: if (step_done) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        spi_reg_addr_o    = cpu_reg_addr_i;
        spi_reg_data_in_o = cpu_reg_data_in_i;
        spi_reg_sel_o     = cpu_reg_sel_i;
        spi_reg_read_o    = cpu_reg_read_i;
        spi_reg_write_o   = cpu_reg_write_i;
        cpu_data_out_o    = spi_data_out_i;
        if (state_q != ST_IDLE) begin
            cpu_data_out_o = '0;
            spi_reg_sel_o  = sel_q;
            if (state_q == ST_CAP) begin
                spi_reg_addr_o    = SPI_REG_NEXT;
                spi_reg_data_in_o = '0;
                spi_reg_read_o    = 1'b1;
                spi_reg_write_o   = 1'b0;
            end else begin
                spi_reg_addr_o    = step_addr;
                spi_reg_data_in_o = step_data;
                spi_reg_read_o    = step_read;
                spi_reg_write_o   = step_write;
            end
        end
    end

    assign req_ready_o = req_accept;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_last_o   = rd_last_q;
    assign done_o      = done_q;
    assign cpu_busy_o  = busy_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural spi register block with a flash device behind it.
module tb_spi_flash_reader;
    import spi_pkg::*;

    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [23:0] req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic [1:0] req_sel = '0;
    logic rd_valid, rd_last, done;
    logic rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [2:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [1:0] cpu_sel = '0;
    logic cpu_read = 1'b0, cpu_write = 1'b0;
    logic [7:0] cpu_rdata;
    logic cpu_busy;
    logic [2:0] spi_addr;
    logic [7:0] spi_din;
    logic [1:0] spi_sel;
    logic spi_read, spi_write;
    logic [7:0] spi_dout;
    fsm_state_e dut_state;
    step_state_e dut_step_state;

    int n_tests = 0;
    int n_fail = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    spi_flash_reader #(.LEN_W(LEN_W), .READ_CMD(FLASH_READ_CMD)) dut (
        .clk_i(clk), .reset_i(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_len_i(req_len), .req_sel_i(req_sel),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .rd_last_o(rd_last), .done_o(done),
        .cpu_reg_addr_i(cpu_addr), .cpu_reg_data_in_i(cpu_wdata), .cpu_reg_sel_i(cpu_sel),
        .cpu_reg_read_i(cpu_read), .cpu_reg_write_i(cpu_write),
        .cpu_data_out_o(cpu_rdata), .cpu_busy_o(cpu_busy),
        .spi_reg_addr_o(spi_addr), .spi_reg_data_in_o(spi_din), .spi_reg_sel_o(spi_sel),
        .spi_reg_read_o(spi_read), .spi_reg_write_o(spi_write),
        .spi_data_out_i(spi_dout),
        .state_o(dut_state), .step_state_o(dut_step_state)
    );

    // Flash contents as a pure function of byte address.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo << 1) ^ (lo >> 3) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // spi register block + flash device model
    logic        m_open = 1'b0;
    logic        m_ready = 1'b1;
    int          m_busy = 0;
    logic [7:0]  m_rx = '0;
    logic [7:0]  m_pending = '0;
    logic [1:0]  m_cs_sel = '0;
    int          m_idx = 0;
    logic [23:0] m_faddr = '0;
    int          m_tx_count = 0;
    int          m_opens = 0;
    logic [7:0]  mosi_log[$];

    always_comb begin
        case (spi_addr)
            3'd1:    spi_dout = m_rx;
            3'd2:    spi_dout = {7'd0, m_ready};
            default: spi_dout = 8'hA5;
        endcase
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            m_open  <= 1'b0;
            m_ready <= 1'b1;
            m_busy  <= 0;
            m_idx   <= 0;
            m_rx    <= '0;
        end else begin
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_ready <= 1'b1;
                    m_rx    <= m_pending;
                end
            end
            if (spi_write && spi_addr == 3'd0) begin
                mosi_log.push_back(spi_din);
                m_tx_count <= m_tx_count + 1;
                m_ready    <= 1'b0;
                m_busy     <= int'($urandom_range(2, 5));
                if (!m_open) begin
                    m_open    <= 1'b1;
                    m_cs_sel  <= spi_sel;
                    m_opens   <= m_opens + 1;
                    m_idx     <= 1;
                    m_pending <= 8'hFF;
                end else begin
                    m_idx <= m_idx + 1;
                    if (m_idx <= 3) begin
                        m_faddr   <= {m_faddr[15:0], spi_din};
                        m_pending <= 8'hFF;
                    end else begin
                        m_pending <= flash_byte(m_faddr + 24'(m_idx - 4));
                    end
                end
            end
            if (spi_read && spi_addr == 3'd0) begin
                m_open  <= 1'b0;
                m_ready <= 1'b0;
                m_busy  <= 2;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one read request (called just after a negedge) and score the whole transaction.
    task automatic run_req(input logic [23:0] a, input int len, input logic [1:0] sel,
                           input int stall_idx, input int stall_len, input bit rand_ready);
        logic [7:0] exp_q[$];
        logic [7:0] exp_mosi[$];
        logic [7:0] held, e;
        int nrx, guard, stall_left, txc, opens0, since_last, extra, nm;
        bit seen_done, busy_chk;
        held = '0; txc = 0; nrx = 0; guard = 0; since_last = 0; extra = 0;
        seen_done = 1'b0; busy_chk = 1'b0; stall_left = stall_len;
        for (int i = 0; i <= len; i++) exp_q.push_back(flash_byte(a + 24'(i)));
        exp_mosi.push_back(FLASH_READ_CMD);
        exp_mosi.push_back(a[23:16]);
        exp_mosi.push_back(a[15:8]);
        exp_mosi.push_back(a[7:0]);
        for (int i = 0; i <= len; i++) exp_mosi.push_back(8'hFF);
        mosi_log.delete();
        opens0 = m_opens;
        req_addr = a; req_len = LEN_W'(len); req_sel = sel; req_valid = 1'b1;
        last_wait = 0;
        #1;
        while (!req_ready && last_wait < 200) begin
            @(negedge clk); last_wait++; #1;
        end
        check_eq("req_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        while (!seen_done && guard < 20000) begin
            if (guard > 0) @(negedge clk);
            guard++;
            since_last++;
            cpu_write = (guard == 10);
            cpu_addr = 3'd0; cpu_wdata = 8'h77;
            if (cpu_busy && !busy_chk) begin
                busy_chk = 1'b1;
                check_eq("cpu_data_out_busy", 32'(cpu_rdata), 32'd0);
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("cs_released_at_done", 32'(m_open), 32'd0);
                check_eq("bytes_at_done", 32'(nrx), 32'(len + 1));
                check_eq("done_after_last_ge2", 32'(since_last >= 3), 32'd1);
            end else if (rd_valid) begin
                if (nrx == stall_idx && stall_left > 0) begin
                    if (stall_left == stall_len) begin
                        held = rd_data; txc = m_tx_count;
                    end else begin
                        check_eq("stall_data_stable", 32'(rd_data), 32'(held));
                    end
                    stall_left--;
                    rd_ready = 1'b0;
                    if (stall_left == 0) begin
                        check_eq("stall_no_spi_bytes", 32'(m_tx_count - txc), 32'd0);
                        check_eq("stall_cs_low", 32'(m_open), 32'd1);
                    end
                end else begin
                    rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (rd_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_byte", 32'(rd_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rd_data", 32'(rd_data), 32'(e));
                        check_eq("rd_last", 32'(rd_last), 32'(exp_q.size() == 0));
                    end
                    nrx++;
                    since_last = 0;
                end
            end else begin
                rd_ready = 1'($urandom_range(0, 1));
            end
        end
        cpu_write = 1'b0;
        rd_ready = 1'b0;
        check_eq("done_seen", 32'(seen_done), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check_eq("done_once", 32'(extra), 32'd0);
        check_eq("mosi_count", 32'(mosi_log.size()), 32'(exp_mosi.size()));
        nm = (mosi_log.size() < exp_mosi.size()) ? mosi_log.size() : exp_mosi.size();
        for (int i = 0; i < nm; i++) check_eq("mosi_byte", 32'(mosi_log[i]), 32'(exp_mosi[i]));
        check_eq("cs_single_open", 32'(m_opens - opens0), 32'd1);
        check_eq("cs_sel", 32'(m_cs_sel), 32'(sel));
        check_eq("busy_cleared", 32'(cpu_busy), 32'd0);
    endtask

    initial begin
        int c0, g;
        bit any_ready;
        // reset with a pending request: nothing may be accepted
        reset_n = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_req_ready", 32'(req_ready), 32'd0);
        check_eq("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("reset_rd_last", 32'(rd_last), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_cpu_busy", 32'(cpu_busy), 32'd0);
        check_eq("reset_rd_data", 32'(rd_data), 32'd0);
        check_eq("reset_state", 32'(dut_state), 32'(ST_IDLE));
        req_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        cpu_addr = 3'd2;
        #1;
        check_eq("idle_passthru_addr", 32'(spi_addr), 32'd2);
        check_eq("idle_passthru_data", 32'(cpu_rdata), 32'd1);
        cpu_addr = 3'd0;
        @(negedge clk);

        // basic read
        run_req(24'h012345, 3, 2'd0, -1, 0, 1'b0);

        // backpressure on the second byte
        @(negedge clk);
        run_req(24'($urandom), 4, 2'd1, 1, 20, 1'b0);

        // open CPU transaction blocks requests until the CPU reads addr0
        @(negedge clk);
        cpu_write = 1'b1; cpu_addr = 3'd0; cpu_wdata = 8'h9F; cpu_sel = 2'd0;
        @(negedge clk);
        cpu_write = 1'b0;
        req_addr = 24'h00ABCD; req_len = 8'd1; req_sel = 2'd2; req_valid = 1'b1;
        any_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req_ready) any_ready = 1'b1;
            @(negedge clk);
        end
        check_eq("req_blocked_cpu_txn", 32'(any_ready), 32'd0);
        cpu_read = 1'b1; cpu_addr = 3'd0;
        #1;
        check_eq("req_ready_during_cpu_read", 32'(req_ready), 32'd0);
        check_eq("cpu_read_passthru", 32'(cpu_rdata), 32'hA5);
        @(negedge clk);
        cpu_read = 1'b0;
        run_req(24'h00ABCD, 1, 2'd2, -1, 0, 1'b1);
        check_eq("accept_after_cpu_read", 32'(last_wait), 32'd0);

        // CPU write and request in the same idle cycle
        @(negedge clk);
        c0 = m_tx_count;
        cpu_write = 1'b1; cpu_addr = 3'd0; cpu_wdata = 8'h5A;
        req_valid = 1'b1;
        #1;
        check_eq("req_ready_cpu_tie", 32'(req_ready), 32'd0);
        @(negedge clk);
        cpu_write = 1'b0; req_valid = 1'b0;
        check_eq("cpu_write_reached_spi", 32'(m_tx_count - c0), 32'd1);
        check_eq("cpu_write_byte", 32'(mosi_log[mosi_log.size() - 1]), 32'h5A);
        repeat (10) @(negedge clk);
        cpu_read = 1'b1; cpu_addr = 3'd0;
        @(negedge clk);
        cpu_read = 1'b0;
        repeat (4) @(negedge clk);

        // random requests
        for (int t = 0; t < 4; t++) begin
            run_req(24'($urandom), int'($urandom_range(0, 6)), 2'($urandom_range(0, 2)),
                    -1, 0, 1'b1);
            @(negedge clk);
        end

        // reset during the A1 byte
        c0 = m_tx_count;
        req_addr = 24'($urandom); req_len = 8'd5; req_sel = 2'd1; req_valid = 1'b1;
        g = 0;
        #1;
        while (!req_ready && g < 200) begin
            @(negedge clk); g++; #1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (m_tx_count - c0 < 3 && g < 500) begin
            @(negedge clk); g++;
        end
        check_eq("reached_a1", 32'(m_tx_count - c0), 32'd3);
        check_eq("state_before_reset", 32'(dut_state), 32'(ST_A1));
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mid_reset_state", 32'(dut_state), 32'(ST_IDLE));
        check_eq("mid_reset_cpu_busy", 32'(cpu_busy), 32'd0);
        check_eq("mid_reset_rd_valid", 32'(rd_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        run_req(24'($urandom), 2, 2'd0, -1, 0, 1'b1);

        // maximum length
        @(negedge clk);
        run_req(24'hFFFF80, 255, 2'd2, -1, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
